sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_pkg.sv | 19 +
 rtl/sseg_hex_decode.sv | 11 +
 rtl/sseg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: hex glyph table, segment bit positions
// and the scan FSM state type.
package sseg_pkg;

  localparam int SEG_LAST = 6;  // segments A..G occupy bits 0..SEG_LAST
  localparam int SEG_DP   = 7;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } sseg_state_e;

  // Entry n is the A..G pattern for hex digit n (entry 15 written first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to seven-segment (A..G, active-high) decoder.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with dead time between digits
// and frame-synchronous (tear-free) double-buffered display updates.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output sseg_state_e             dbg_state
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

  sseg_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] pend_val_q, act_val_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q;
  logic                    pend_lz_q, act_lz_q;
  logic                    pend_vld_q;

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  logic [NUM_DIGITS-1:0]   dark;
  logic [3:0]              nib_sel;
  logic [6:0]              dec_seg;

  // Scan sequencing: DEAD gap, then SHOW one digit, then advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == REFRESH_LAST) begin
          state_d = ST_DEAD;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_DEAD;
        cnt_d   = '0;
      end
    endcase
  end

  // A digit is dark if blanked, or (with lz) if it and every higher nibble is zero.
  always_comb begin
    dark = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dark[i] = act_blank_q[i] |
                (act_lz_q && (i != 0) && ((act_val_q >> (4 * i)) == '0));
    end
  end

  assign nib_sel = act_val_q[4*idx_d +: 4];

  sseg_hex_decode u_dec (
    .nibble_i (nib_sel),
    .seg_o    (dec_seg)
  );

  // Outputs are computed from next state so the registered pins line up
  // with the FSM state register.
  always_comb begin
    an_d  = '0;
    seg_d = '0;
    if (state_d == ST_SHOW) begin
      an_d = NUM_DIGITS'(1) << idx_d;
      if (!dark[idx_d]) begin
        seg_d[SEG_LAST:0] = dec_seg;
        seg_d[SEG_DP]     = act_dp_q[idx_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DEAD;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= wrap;
    end
  end

  // Shadow registers: a load on the wrap edge is kept for the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_lz_q    <= 1'b0;
      pend_vld_q   <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      act_lz_q     <= 1'b0;
    end else begin
      if (wrap && pend_vld_q) begin
        act_val_q   <= pend_val_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
        act_lz_q    <= pend_lz_q;
      end
      if (load) begin
        pend_val_q   <= value;
        pend_dp_q    <= dp_mask;
        pend_blank_q <= blank_mask;
        pend_lz_q    <= lz_en;
        pend_vld_q   <= 1'b1;
      end else if (wrap) begin
        pend_vld_q   <= 1'b0;
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: table vectors, tear/reset sequences and random
// loads checked cycle by cycle against a frame-position reference model.
module tb_sseg_scan_ctrl;
  import sseg_pkg::*;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int D     = 1;
  localparam int SLOT  = R + D;
  localparam int FRAME = N * SLOT;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value = '0;
  logic [3:0]    dp_mask = '0;
  logic [3:0]    blank_mask = '0;
  logic          lz_en = 1'b0;
  logic          load = 1'b0;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic          frame_done;
  sseg_state_e   dbg_state;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int k;                         // rising edges since reset release
  logic [6:0]  hex7 [16];
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, p_dp, m_blank, p_blank;
  logic        m_lz, p_lz, p_flag;
  logic [13:0] exp_q[$];         // {show, frame_done, an, seg}
  logic [3:0]  last_an;
  logic [7:0]  last_seg;
  logic        last_fd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, got, exp, k, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: expected event not seen within %0d cycles", name, 2 * FRAME);
  endtask

  task automatic model_clear();
    k = 0;
    m_val = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
    p_val = '0; p_dp = '0; p_blank = '0; p_lz = 1'b0; p_flag = 1'b0;
    exp_q.delete();
  endtask

  // Display content is a pure function of position within the 20-cycle frame.
  function automatic logic [13:0] predict();
    int pos, d;
    logic lit, dk;
    logic [3:0] a, nib;
    logic [7:0] s;
    pos = k % FRAME;
    d   = pos / SLOT;
    lit = (pos % SLOT) >= D;
    a   = lit ? 4'(1 << d) : 4'b0000;
    nib = m_val[4*d +: 4];
    dk  = m_blank[d] || (m_lz && d > 0 && (m_val >> (4 * d)) == 16'h0000);
    s   = (lit && !dk) ? {m_dp[d], hex7[nib]} : 8'h00;
    return {lit, (k > 0 && pos == 0), a, s};
  endfunction

  task automatic tick();
    logic [13:0] e;
    @(posedge clk);
    k++;
    if (k % FRAME == 0 && p_flag) begin
      m_val = p_val; m_dp = p_dp; m_blank = p_blank; m_lz = p_lz;
      p_flag = 1'b0;
    end
    if (load) begin
      p_val = value; p_dp = dp_mask; p_blank = blank_mask; p_lz = lz_en;
      p_flag = 1'b1;
    end
    exp_q.push_back(predict());
    @(negedge clk);
    last_an  = an;
    last_seg = seg;
    last_fd  = frame_done;
    e = exp_q.pop_front();
    check("scan", {dbg_state == ST_SHOW, frame_done, an, seg}, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async", {an, seg, frame_done}, 32'h0);
    @(negedge clk);
    check("rst_hold", {dbg_state == ST_SHOW, an, seg, frame_done}, 32'h0);
    rst = 1'b0;
    model_clear();
    check("rst_release", {dbg_state == ST_SHOW, an, seg, frame_done}, 32'h0);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_fd && n < 2 * FRAME);
    if (!last_fd) timeout_fail("wait_frame_done");
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_an != target && n < 2 * FRAME);
    if (last_an != target) timeout_fail("wait_an");
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input logic lz);
    value = v; dp_mask = dp; blank_mask = bl; lz_en = lz;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][7:0] exp;      // exp[d] = seg for digit d
  } vec_t;

  vec_t vecs [7];

  initial begin
    hex7 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{16'h12AE, 4'b0000, 4'b0000, 1'b0, {8'h06, 8'h5B, 8'h77, 8'h79}};
    vecs[1] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'h00, 8'h00, 8'h00, 8'h3F}};
    vecs[2] = '{16'h0050, 4'b0010, 4'b0000, 1'b1, {8'h00, 8'h00, 8'hED, 8'h3F}};
    vecs[3] = '{16'h12AE, 4'b0000, 4'b1000, 1'b0, {8'h00, 8'h5B, 8'h77, 8'h79}};
    vecs[4] = '{16'h8888, 4'b1010, 4'b0000, 1'b0, {8'hFF, 8'h7F, 8'hFF, 8'h7F}};
    vecs[5] = '{16'h0A0C, 4'b0000, 4'b0000, 1'b1, {8'h00, 8'h77, 8'h3F, 8'h39}};
    vecs[6] = '{16'h00F0, 4'b1111, 4'b0010, 1'b1, {8'h00, 8'h00, 8'h00, 8'hBF}};

    model_clear();
    do_reset();

    // First SHOW after reset: digit 0 of an all-zero display.
    tick();
    check("first_show", {an, seg}, {4'b0001, 8'h3F});

    // Table vectors: load, wait for the wrap, check every lit cycle of a frame.
    for (int v = 0; v < 7; v++) begin
      load_pulse(vecs[v].val, vecs[v].dp, vecs[v].blank, vecs[v].lz);
      wait_fd();
      for (int c = 0; c < FRAME - 1; c++) begin
        tick();
        for (int j = 0; j < N; j++)
          if (last_an == 4'(1 << j)) check($sformatf("vec%0d_d%0d", v, j), last_seg, vecs[v].exp[j]);
      end
    end

    // No tearing: a load during digit 2 leaves digits 2..3 on the old value.
    load_pulse(16'h12AE, 4'b0000, 4'b0000, 1'b0);
    wait_fd();
    wait_an(4'b0100);
    load_pulse(16'hFFFF, 4'b0000, 4'b0000, 1'b0);
    for (int c = 0; c < 2 * FRAME && !last_fd; c++) begin
      tick();
      if (last_an == 4'b0100) check("tear_d2_old", last_seg, 8'h5B);
      if (last_an == 4'b1000) check("tear_d3_old", last_seg, 8'h06);
    end
    if (!last_fd) timeout_fail("tear_wrap");
    wait_an(4'b0001);
    check("tear_d0_new", last_seg, 8'h71);

    // Load on the frame_done cycle is deferred to the following wrap.
    wait_fd();
    load_pulse(16'h3333, 4'b0000, 4'b0000, 1'b0);
    wait_an(4'b0001);
    check("wrap_load_deferred", last_seg, 8'h71);
    wait_fd();
    wait_an(4'b0001);
    check("wrap_load_applied", last_seg, 8'h4F);

    // Two loads in one frame: only the last applies.
    wait_fd();
    load_pulse(16'h1111, 4'b0000, 4'b0000, 1'b0);
    tick();
    load_pulse(16'h2222, 4'b0000, 4'b0000, 1'b0);
    wait_fd();
    wait_an(4'b0001);
    check("last_load_wins", last_seg, 8'h5B);

    // Reset pulsed in the middle of a SHOW window.
    wait_an(4'b0010);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_show", {an, seg, frame_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("rst_mid_release", {an, seg}, 32'h0);
    tick();
    check("rst_mid_first", {an, seg}, {4'b0001, 8'h3F});

    // Random inputs and sparse loads against the model.
    for (int c = 0; c < 400; c++) begin
      value      = 16'($urandom);
      dp_mask    = 4'($urandom_range(0, 15));
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      lz_en      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
      load       = ($urandom_range(0, 12) == 0);
      tick();
    end
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
